// File: rtl/hdmi_log_arbiter_pkg.sv
// Shared widths, FSM encoding and output-word packing for the HDMI log arbiter.
// Replaces the old hdmi_log_defs.vh header.
package hdmi_log_arbiter_pkg;
    localparam int HDMI_WORD_W = 40;
    localparam int CH_ID_W     = 4;
    localparam int SEQ_W       = 4;
    localparam int LOG_OUT_W   = 48;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    typedef logic [LOG_OUT_W-1:0] log_word_t;

    function automatic log_word_t pack_word(logic [CH_ID_W-1:0] id, logic [SEQ_W-1:0] seq,
                                            logic [HDMI_WORD_W-1:0] word);
        return {id, seq, word};
    endfunction
endpackage

// File: rtl/hdmi_log_arbiter_if.sv
// Channel FIFO read ports plus tagged output stream of the HDMI log arbiter.
interface hdmi_log_arbiter_if #(parameter int NUM_CH = 3);
    import hdmi_log_arbiter_pkg::*;

    logic [NUM_CH-1:0]             ch_enable;
    logic [NUM_CH-1:0]             ch_empty;
    logic [NUM_CH-1:0]             ch_read;
    logic [NUM_CH*HDMI_WORD_W-1:0] ch_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [LOG_OUT_W-1:0]          out_data;
    logic                          busy;

    modport master (
        output ch_enable, ch_empty, ch_data, out_ready,
        input  ch_read, out_valid, out_data, busy
    );

    modport slave (
        input  ch_enable, ch_empty, ch_data, out_ready,
        output ch_read, out_valid, out_data, busy
    );
endinterface

// File: rtl/hdmi_log_arbiter_skid.sv
// Two-entry in-order output buffer; the head entry drives the output directly.
module hdmi_log_arbiter_skid
    import hdmi_log_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  log_word_t  i_din,
    input  logic       i_pop,
    output logic       o_valid,
    output log_word_t  o_dout,
    output logic [1:0] o_occ
);
    logic [1:0] r_occ;
    log_word_t  r_head;
    log_word_t  r_tail;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy holds; the new word lands behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_dout  = r_head;
    assign o_occ   = r_occ;
endmodule

// File: rtl/hdmi_log_arbiter.sv
// Round-robin burst reader for per-channel HDMI capture FIFOs, merged into one
// tagged {ch_id, seq, word} stream through a two-entry output buffer.
module hdmi_log_arbiter
    import hdmi_log_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int BURST_LEN = 8
) (
    input logic               i_log_clk,
    input logic               i_reset,
    hdmi_log_arbiter_if.slave io_bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = $clog2(BURST_LEN + 1);

    state_t                        r_state, w_state_nxt;
    logic [CH_W-1:0]               r_rr, w_rr_nxt;
    logic [CH_W-1:0]               r_gnt, w_gnt_nxt, w_gnt_inc;
    logic [CH_W-1:0]               r_pend_ch;
    logic [BC_W-1:0]               r_burst, w_burst_nxt;
    logic                          r_pending;
    logic [NUM_CH-1:0][SEQ_W-1:0]  r_seq;

    logic [NUM_CH-1:0] w_read;
    logic              w_issue, w_pop, w_room, w_found, w_skid_valid;
    logic [CH_W-1:0]   w_idx;
    logic [1:0]        w_occ;
    logic [2:0]        w_fill;
    log_word_t         w_cap, w_head;

    assign w_pop     = w_skid_valid & io_bus.out_ready;
    assign w_fill    = {1'b0, w_occ} + {2'b00, r_pending};
    assign w_room    = (w_fill < (3'd2 + {2'b00, w_pop}));
    assign w_gnt_inc = (r_gnt == CH_W'(NUM_CH - 1)) ? '0 : r_gnt + CH_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_gnt_nxt   = r_gnt;
        w_burst_nxt = r_burst;
        w_read      = '0;
        w_issue     = 1'b0;
        w_found     = 1'b0;
        w_idx       = '0;
        case (r_state)
            ST_IDLE: begin
                // Walk from the far end so the channel closest to rr wins.
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    w_idx = CH_W'((int'(r_rr) + i) % NUM_CH);
                    if (io_bus.ch_enable[w_idx] && !io_bus.ch_empty[w_idx]) begin
                        w_gnt_nxt = w_idx;
                        w_found   = 1'b1;
                    end
                end
                if (w_found) begin
                    w_state_nxt = ST_READ;
                    w_burst_nxt = '0;
                end
            end
            ST_READ: begin
                if (!io_bus.ch_enable[r_gnt]) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_gnt_inc;
                end else if (w_room) begin
                    if (io_bus.ch_empty[r_gnt]) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = w_gnt_inc;
                    end else begin
                        w_issue       = 1'b1;
                        w_read[r_gnt] = 1'b1;
                        w_burst_nxt   = r_burst + BC_W'(1);
                        if (r_burst == BC_W'(BURST_LEN - 1)) begin
                            w_state_nxt = ST_IDLE;
                            w_rr_nxt    = w_gnt_inc;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_log_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_rr      <= '0;
            r_gnt     <= '0;
            r_burst   <= '0;
            r_pending <= 1'b0;
            r_pend_ch <= '0;
            r_seq     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_burst   <= w_burst_nxt;
            r_pending <= w_issue;
            if (w_issue)   r_pend_ch <= r_gnt;
            if (r_pending) r_seq[r_pend_ch] <= r_seq[r_pend_ch] + SEQ_W'(1);
        end
    end

    // FIFO q is valid the cycle after rdreq, so capture uses the channel latched at issue.
    assign w_cap = pack_word(CH_ID_W'(r_pend_ch), r_seq[r_pend_ch],
                             io_bus.ch_data[r_pend_ch*HDMI_WORD_W +: HDMI_WORD_W]);

    hdmi_log_arbiter_skid u_skid (
        .i_clk   (i_log_clk),
        .i_rst   (i_reset),
        .i_push  (r_pending),
        .i_din   (w_cap),
        .i_pop   (w_pop),
        .o_valid (w_skid_valid),
        .o_dout  (w_head),
        .o_occ   (w_occ)
    );

    assign io_bus.ch_read   = w_read;
    assign io_bus.out_valid = w_skid_valid;
    assign io_bus.out_data  = w_head;
    assign io_bus.busy      = (r_state == ST_READ) | r_pending | (w_occ != 2'd0);
endmodule

// File: tb/tb_hdmi_log_arbiter.sv
// Directed bench for hdmi_log_arbiter: FIFO models, output monitor, hand-built expected streams.
module tb_hdmi_log_arbiter;
    import hdmi_log_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int BL  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_log_arbiter_if #(.NUM_CH(NCH)) bus ();

    hdmi_log_arbiter #(.NUM_CH(NCH), .BURST_LEN(BL)) dut (
        .i_log_clk (clk),
        .i_reset   (rst),
        .io_bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Normal-mode FIFO models: q updates the cycle after rdreq.
    logic [39:0]        mem [NCH][64];
    int                 wr_cnt [NCH];
    int                 rd_ptr [NCH];
    logic               fifo_clr;
    logic [NCH*40-1:0]  q_reg;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (fifo_clr) rd_ptr[i] <= 0;
            else if (bus.ch_read[i]) begin
                q_reg[i*40 +: 40] <= mem[i][rd_ptr[i]];
                rd_ptr[i]         <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        bus.ch_empty = '0;
        for (int i = 0; i < NCH; i++) bus.ch_empty[i] = (rd_ptr[i] >= wr_cnt[i]);
    end
    assign bus.ch_data = q_reg;

    function automatic logic [39:0] wd(input int ch, input int n);
        return {8'(8'hA0 + ch), 32'(n)};
    endfunction

    function automatic logic [47:0] ex(input int ch, input int sq, input int n);
        return {4'(ch), 4'(sq), wd(ch, n)};
    endfunction

    // Monitor: issue log, accepted words, hold-while-stalled and issue-room rules.
    logic [47:0] got [$];
    int          iss_ch [$];
    int          iss_cyc [$];
    int          cyc = 0;
    int          n_out = 0;
    logic        prev_stall = 1'b0;
    logic [47:0] prev_data = '0;

    always @(negedge clk) begin
        logic pop;
        logic rd;
        int   c;
        cyc++;
        if (rst) begin
            n_out      = 0;
            prev_stall = 1'b0;
        end else begin
            pop = bus.out_valid && bus.out_ready;
            rd  = (bus.ch_read != '0);
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'(bus.out_data), 64'(prev_data));
            end
            if (rd) begin
                chk("read_onehot", 64'($onehot(bus.ch_read)), 64'd1);
                chk("read_room", 64'((n_out - int'(pop)) < 2), 64'd1);
                c = 0;
                for (int i = 0; i < NCH; i++) if (bus.ch_read[i]) c = i;
                iss_ch.push_back(c);
                iss_cyc.push_back(cyc);
            end
            if (pop) got.push_back(bus.out_data);
            n_out      = n_out + int'(rd) - int'(pop);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    logic [47:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_cnt[ch]] = wd(ch, wr_cnt[ch]);
            wr_cnt[ch]++;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ch_enable = '1;
        bus.out_ready = 1'b1;
        fifo_clr      = 1'b1;
        for (int i = 0; i < NCH; i++) wr_cnt[i] = 0;
        tick();
        tick();
        fifo_clr = 1'b0;
        rst      = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int max, input bit toggle);
        int quiet = 0;
        for (int c = 0; c < max && quiet < 3; c++) begin
            tick();
            if (toggle) bus.out_ready = ~bus.out_ready;
            if (!bus.busy) quiet++;
            else           quiet = 0;
        end
        if (quiet < 3) chk("drain_timeout", 64'd0, 64'd1);
        bus.out_ready = 1'b1;
    endtask

    task automatic cmp_words(input string t, input int base);
        chk({t, "_count"}, 64'(got.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", t, i), 64'((base + i < got.size()) ? got[base + i] : 48'd0),
                64'(exp_q[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bg, bi, c;
        rst           = 1'b1;
        fifo_clr      = 1'b1;
        bus.ch_enable = '1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) wr_cnt[i] = 0;
        tick();
        tick();
        chk("rst_ch_read", 64'(bus.ch_read), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        fifo_clr = 1'b0;
        rst      = 1'b0;
        tick();

        // 1: two words on ch1, back-to-back reads
        bg = got.size(); bi = iss_ch.size();
        load(1, 2);
        wait_idle(200, 1'b0);
        chk("t1_nread", 64'(iss_ch.size() - bi), 64'd2);
        chk("t1_ch_a", 64'(iss_ch[bi]), 64'd1);
        chk("t1_ch_b", 64'(iss_ch[bi+1]), 64'd1);
        chk("t1_b2b", 64'(iss_cyc[bi+1] - iss_cyc[bi]), 64'd1);
        exp_q.delete();
        exp_q.push_back(ex(1, 0, 0));
        exp_q.push_back(ex(1, 1, 1));
        cmp_words("t1", bg);
        chk("t1_busy", 64'(bus.busy), 64'd0);
        chk("t1_ch_read", 64'(bus.ch_read), 64'd0);

        // 2: 20 words per channel, bursts of 8 in round-robin order
        do_reset();
        bg = got.size(); bi = iss_ch.size();
        for (int ch = 0; ch < NCH; ch++) load(ch, 20);
        wait_idle(500, 1'b0);
        exp_q.delete();
        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < NCH; ch++)
                for (int k = 0; k < BL; k++)
                    if (r*BL + k < 20) exp_q.push_back(ex(ch, (r*BL + k) % 16, r*BL + k));
        cmp_words("t2", bg);
        chk("t2_gap01", 64'(iss_cyc[bi+8]  - iss_cyc[bi+7]),  64'd2);
        chk("t2_gap12", 64'(iss_cyc[bi+16] - iss_cyc[bi+15]), 64'd2);
        chk("t2_gap20", 64'(iss_cyc[bi+24] - iss_cyc[bi+23]), 64'd2);

        // 3: 20 words on ch0 with out_ready toggling
        do_reset();
        bg = got.size();
        load(0, 20);
        wait_idle(1000, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(ex(0, i % 16, i));
        cmp_words("t3", bg);

        // 4: disable ch1 right after its third read
        do_reset();
        bg = got.size(); bi = iss_ch.size();
        load(1, 10);
        load(2, 3);
        c = 0;
        while (iss_ch.size() - bi < 3 && c < 100) begin
            tick();
            c++;
        end
        chk("t4_reads_seen", 64'(iss_ch.size() - bi), 64'd3);
        bus.ch_enable[1] = 1'b0;
        wait_idle(200, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(ex(1, i, i));
        for (int i = 0; i < 3; i++) exp_q.push_back(ex(2, i, i));
        cmp_words("t4", bg);
        c = 0;
        for (int i = bi; i < iss_ch.size(); i++) if (iss_ch[i] == 1) c++;
        chk("t4_ch1_reads", 64'(c), 64'd3);

        // 5: 17 words on ch2, seq wraps
        do_reset();
        bg = got.size();
        load(2, 17);
        wait_idle(300, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 17; i++) exp_q.push_back(ex(2, i % 16, i));
        cmp_words("t5", bg);

        // 6: reset the cycle after a read; rr and seq restart
        do_reset();
        load(1, 2);
        wait_idle(200, 1'b0);
        bi = iss_ch.size();
        load(1, 2);
        c = 0;
        while (iss_ch.size() == bi && c < 100) begin
            tick();
            c++;
        end
        chk("t6_read_seen", 64'(iss_ch.size() - bi), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_ch_read", 64'(bus.ch_read), 64'd0);
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_data", 64'(bus.out_data), 64'd0);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        tick();
        load(0, 1);
        load(2, 1);
        bg  = got.size();
        rst = 1'b0;
        wait_idle(200, 1'b0);
        exp_q.delete();
        exp_q.push_back(ex(0, 0, 0));
        exp_q.push_back(ex(1, 0, 3));
        exp_q.push_back(ex(2, 0, 0));
        cmp_words("t6", bg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
